base34_pack: RTL and testbench
==============================

Name: base34_pack

Overview:
- Sequential inverse of the mod-34 reduction path: rebuilds a binary word from a stream of base-34 digits (most significant first) using Horner accumulation, acc <= acc*34 + d.
- Multiply-by-34 is shift-add only ((acc<<5) + (acc<<1)); no DSP.
- Sits downstream of digit producers in the HQC encap datapath.
- Valid/ready on both the digit input and the packed-word output.

Parameters:
- NUM_DIGITS, 2, digits per packed word; >= 1.
- OUT_W, 12, output word width; must satisfy 2^OUT_W >= 34^NUM_DIGITS.
- CNT_W, 4, digit counter width; must satisfy 2^CNT_W > NUM_DIGITS.

Ports:
- clk  input  1  clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- digit_i  input  6  base-34 digit, MS digit first
- digit_valid_i  input  1  digit_i valid
- digit_ready_o  output  1  block accepts a digit this cycle
- word_o  output  OUT_W  packed word
- word_valid_o  output  1  word_o valid
- word_ready_i  input  1  consumer accepts word_o
- err_o  output  1  sticky out-of-range-digit flag; present only with DIGIT_CHECK_EN

Behaviour:
- Reset is synchronous and active-high on clk. While rst=1 at a clock edge: state=ACCUM, acc=0, cnt=0, word_valid_o=0, err_o=0.
- Reset wins over every other event and aborts a partial word. No partial data survives reset.
- After reset: digit_ready_o=1, word_o=0.
- States: ACCUM, HOLD.
- ACCUM:
  - digit_ready_o=1, word_valid_o=0.
  - A digit is accepted on a cycle where digit_valid_i=1 and digit_ready_o=1.
  - On accept: acc <= ((acc<<5)+(acc<<1)+digit_i) truncated to OUT_W, and cnt <= cnt+1.
  - If cnt==NUM_DIGITS-1 at accept, go to HOLD and reset cnt to 0.
- HOLD:
  - digit_ready_o=0, word_valid_o=1, word_o=acc.
  - word_o stays stable until the handshake (word_valid_o=1 and word_ready_i=1).
  - On handshake: acc <= 0, go to ACCUM.
- Latency: word_valid_o rises the cycle after the last digit is accepted.
- Throughput: one bubble per word. Digits are never accepted in the handshake cycle, so the first digit of the next word is accepted no earlier than the cycle after the word handshake.
- Gaps on digit_valid_i are allowed. acc and cnt hold while no digit is accepted.
- digit_i and digit_valid_i are ignored in HOLD.
- word_ready_i is ignored in ACCUM.
- Arithmetic:
  - Intermediate sum computed at OUT_W+6 bits.
  - Result truncated to OUT_W (mod 2^OUT_W). Truncation cannot occur for in-range digits when the OUT_W constraint is met.
- Digit values 34..63 are not range-checked by default. They are accepted and used arithmetically as-is.
- word_o equals acc in every state. It is meaningful only while word_valid_o=1.

Optional Feature:
- Macro: DIGIT_CHECK_EN.
- Defined:
  - err_o port exists.
  - err_o is set the cycle after any accepted digit with digit_i>=34 and stays 1 until rst.
  - The offending digit is still accumulated; word flow is unchanged.
- Undefined:
  - No err_o port and no compare logic.
  - All other behaviour identical.

Test Plan:
1. Defaults. Reset, then digits 33,33 back-to-back, word_ready_i=1 -> word_valid_o=1 for one cycle, one cycle after the second accept, with word_o=1155 (0x483). digit_ready_o=0 during that cycle.
2. Digits 0,0 then 1,0 then 0,5 with random digit_valid_i gaps -> words 0, 34, 5 in order. No digit lost or duplicated; acc holds across gaps.
3. Digits 12,7, then word_ready_i=0 for 5 cycles -> word_o=415 stable and word_valid_o=1 throughout; digit_ready_o=0; digits presented meanwhile are not consumed. Raise ready -> handshake, then digit_ready_o=1 next cycle.
4. Accept digit 20, assert rst for 1 cycle, then digits 2,3 -> word_o=71. The partial 20 is discarded and word_valid_o stays 0 during reset.
5. DIGIT_CHECK_EN defined, digits 40,1 -> err_o=1 from the cycle after the 40 is accepted, word_o=1361. err_o stays 1 through later good words and clears only on rst. Repeat undefined -> word_o=1361 and the build has no err_o port.
6. NUM_DIGITS=3, OUT_W=16, CNT_W=4, digits 33,33,33 -> word_o=39303 (34^3-1).

Source files
------------

// File: rtl/base34_pack.sv
// rtl/base34_pack.sv - Horner packer rebuilding a binary word from MS-first base-34 digits.
// Optional sticky out-of-range digit flag err_o when DIGIT_CHECK_EN is defined.
module base34_pack #(
  parameter int NUM_DIGITS = 2,
  parameter int OUT_W      = 12,
  parameter int CNT_W      = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       digit_i,
  input  logic             digit_valid_i,
  output logic             digit_ready_o,
  output logic [OUT_W-1:0] word_o,
  output logic             word_valid_o,
  input  logic             word_ready_i
`ifdef DIGIT_CHECK_EN
  ,
  output logic             err_o
`endif
);

  typedef enum logic {ACCUM, HOLD} state_t;

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_DIGITS - 1);

  state_t           state;
  logic [OUT_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic [OUT_W+5:0] acc_ext;
  logic [OUT_W+5:0] sum;

  // acc*34 + d as two shifts and adds, kept wide so nothing wraps before truncation
  assign acc_ext = {6'b0, acc};
  assign sum     = (acc_ext << 5) + (acc_ext << 1) + {{OUT_W{1'b0}}, digit_i};
  assign word_o  = acc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ACCUM;
      acc           <= '0;
      cnt           <= '0;
      digit_ready_o <= 1'b1;
      word_valid_o  <= 1'b0;
`ifdef DIGIT_CHECK_EN
      err_o         <= 1'b0;
`endif
    end else begin
      case (state)
        ACCUM: begin
          if (digit_valid_i) begin
            acc <= sum[OUT_W-1:0];
`ifdef DIGIT_CHECK_EN
            if (digit_i >= 6'd34) err_o <= 1'b1;
`endif
            if (cnt == LAST_CNT) begin
              cnt           <= '0;
              state         <= HOLD;
              digit_ready_o <= 1'b0;
              word_valid_o  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        HOLD: begin
          // no digit is taken in the handshake cycle; ready reappears next cycle
          if (word_ready_i) begin
            acc           <= '0;
            state         <= ACCUM;
            word_valid_o  <= 1'b0;
            digit_ready_o <= 1'b1;
          end
        end
        default: begin
          state         <= ACCUM;
          digit_ready_o <= 1'b1;
          word_valid_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_base34_pack.sv
// tb/tb_base34_pack.sv - table-driven scoreboard bench for base34_pack (default and 3-digit builds).
module tb_base34_pack;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [5:0]  digit_i = '0;
  logic        digit_valid_i = 1'b0;
  logic        digit_ready_o;
  logic [11:0] word_o;
  logic        word_valid_o;
  logic        word_ready_i = 1'b1;
`ifdef DIGIT_CHECK_EN
  logic        err_o;
`endif

  logic [5:0]  d3_digit = '0;
  logic        d3_valid = 1'b0;
  logic        d3_ready;
  logic [15:0] d3_word;
  logic        d3_word_valid;
  logic        d3_word_ready = 1'b1;
`ifdef DIGIT_CHECK_EN
  logic        d3_err;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  base34_pack u_dut (
    .clk(clk), .rst(rst), .digit_i(digit_i), .digit_valid_i(digit_valid_i),
    .digit_ready_o(digit_ready_o), .word_o(word_o), .word_valid_o(word_valid_o),
    .word_ready_i(word_ready_i)
`ifdef DIGIT_CHECK_EN
    , .err_o(err_o)
`endif
  );

  base34_pack #(.NUM_DIGITS(3), .OUT_W(16), .CNT_W(4)) u_dut3 (
    .clk(clk), .rst(rst), .digit_i(d3_digit), .digit_valid_i(d3_valid),
    .digit_ready_o(d3_ready), .word_o(d3_word), .word_valid_o(d3_word_valid),
    .word_ready_i(d3_word_ready)
`ifdef DIGIT_CHECK_EN
    , .err_o(d3_err)
`endif
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  // scoreboard pop on every word handshake
  always @(negedge clk) begin
    if (!rst && word_valid_o && word_ready_i) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL word_unexpected: got %0d expected none", word_o);
      end else begin
        logic [11:0] w;
        w = exp_q.pop_front();
        if (word_o !== w) begin
          n_fail++;
          $display("FAIL word: got %0d expected %0d", word_o, w);
        end
      end
    end
  end

  // called and returns at posedge+1; digit accepted on the edge where ready was seen high
  task automatic send_digit(input logic [5:0] d, input int gap);
    int n;
    digit_valid_i = 1'b0;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
    end
    digit_valid_i = 1'b1;
    digit_i = d;
    n = 0;
    while (!digit_ready_o && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL digit_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    digit_valid_i = 1'b0;
  endtask

  task automatic send3(input logic [5:0] d);
    int n;
    d3_valid = 1'b1;
    d3_digit = d;
    n = 0;
    while (!d3_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 50) begin
      n_cmp++;
      n_fail++;
      $display("FAIL d3_timeout: got ready=0 expected ready=1");
    end
    @(posedge clk); #1;
    d3_valid = 1'b0;
  endtask

  typedef struct {
    logic [5:0]  d0;
    logic [5:0]  d1;
    logic [11:0] exp;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int n;
    vecs[0] = '{6'd33, 6'd33, 12'd1155};
    vecs[1] = '{6'd0,  6'd0,  12'd0};
    vecs[2] = '{6'd1,  6'd0,  12'd34};
    vecs[3] = '{6'd0,  6'd5,  12'd5};
    vecs[4] = '{6'd12, 6'd7,  12'd415};
    vecs[5] = '{6'd33, 6'd0,  12'd1122};
    vecs[6] = '{6'd40, 6'd1,  12'd1361};
    vecs[7] = '{6'd63, 6'd63, 12'd2205};

    repeat (3) @(posedge clk);
    #1;
    check("rst_digit_ready", digit_ready_o, 1);
    check("rst_word_valid", word_valid_o, 0);
    check("rst_word_o", word_o, 0);
    rst = 1'b0;

    // back-to-back, then with random gaps
    for (int pass = 0; pass < 2; pass++) begin
      for (int i = 0; i < 8; i++) begin
        exp_q.push_back(vecs[i].exp);
        send_digit(vecs[i].d0, pass == 0 ? 0 : int'($urandom_range(0, 3)));
        send_digit(vecs[i].d1, pass == 0 ? 0 : int'($urandom_range(0, 3)));
        check("latency_valid", word_valid_o, 1);
        check("hold_digit_ready", digit_ready_o, 0);
`ifdef DIGIT_CHECK_EN
        if (i == 6) check("err_set", err_o, 1);
`endif
        @(posedge clk); #1;
        check("post_hs_valid", word_valid_o, 0);
        check("post_hs_ready", digit_ready_o, 1);
      end
    end

    // backpressure: word held while stray digits are offered
    word_ready_i = 1'b0;
    exp_q.push_back(12'd415);
    send_digit(6'd12, 0);
    send_digit(6'd7, 0);
    for (int c = 0; c < 5; c++) begin
      digit_valid_i = 1'b1;
      digit_i = 6'd9;
      check("stall_valid", word_valid_o, 1);
      check("stall_word", word_o, 415);
      check("stall_ready", digit_ready_o, 0);
      @(posedge clk); #1;
    end
    digit_valid_i = 1'b0;
    word_ready_i = 1'b1;
    @(posedge clk); #1;
    check("resume_ready", digit_ready_o, 1);
    check("resume_valid", word_valid_o, 0);

    // partial word aborted by reset
    send_digit(6'd20, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_valid", word_valid_o, 0);
    check("rst_mid_word", word_o, 0);
    rst = 1'b0;
    exp_q.push_back(12'd71);
    send_digit(6'd2, 0);
    send_digit(6'd3, 0);
    check("after_rst_word", word_o, 71);
    @(posedge clk); #1;

    // three-digit build
    send3(6'd33);
    send3(6'd33);
    send3(6'd33);
    check("d3_valid", d3_word_valid, 1);
    check("d3_word_max", d3_word, 39303);
    @(posedge clk); #1;
    send3(6'd1);
    send3(6'd2);
    send3(6'd3);
    check("d3_word_123", d3_word, 1227);
    @(posedge clk); #1;

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 0);

`ifdef DIGIT_CHECK_EN
    check("err_sticky", err_o, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("err_cleared", err_o, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
